// File: rtl/dsp_op_sequencer.sv
// Request/response sequencer driving a DSP48A1 slice through one operation at a time.
// Optional feature: define DSPSEQ_OPCOUNT_EN to add the OP_COUNT response counter output.
module dsp_op_sequencer #(
    parameter int ABD_WIDTH    = 18,
    parameter int CP_WIDTH     = 48,
    parameter int OPMODE_WIDTH = 8,
    parameter int LATENCY      = 4,
    parameter int INIT_CYCLES  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [ABD_WIDTH-1:0]    REQ_A,
    input  logic [ABD_WIDTH-1:0]    REQ_B,
    input  logic [ABD_WIDTH-1:0]    REQ_D,
    input  logic [CP_WIDTH-1:0]     REQ_C,
    input  logic [OPMODE_WIDTH-1:0] REQ_OPMODE,
    input  logic                    REQ_CARRYIN,
    output logic [ABD_WIDTH-1:0]    A,
    output logic [ABD_WIDTH-1:0]    B,
    output logic [ABD_WIDTH-1:0]    D,
    output logic [CP_WIDTH-1:0]     C,
    output logic [OPMODE_WIDTH-1:0] OPMODE,
    output logic                    CARRYIN,
    output logic                    DSP_CE,
    output logic                    DSP_RST,
    input  logic [CP_WIDTH-1:0]     P,
    input  logic                    CARRYOUT,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [CP_WIDTH-1:0]     RSP_P,
    output logic                    RSP_CARRYOUT,
`ifdef DSPSEQ_OPCOUNT_EN
    output logic [15:0]             OP_COUNT,
`endif
    output logic [2:0]              DBG_STATE
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int ICW   = $clog2(INIT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ICW-1:0]          init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ABD_WIDTH-1:0]    a_q, b_q, d_q;
    logic [CP_WIDTH-1:0]     c_q, rsp_p_q;
    logic [OPMODE_WIDTH-1:0] opmode_q;
    logic                    carryin_q, rsp_co_q;
    logic                    accept, capture, rsp_hs;

    // Valid/ready: a transfer happens on a rising edge where both VALID and READY are high;
    // the producer holds VALID and its payload stable until that edge.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_hs     = 1'b0;
        REQ_READY  = 1'b0;
        DSP_CE     = 1'b0;
        DSP_RST    = 1'b0;
        RSP_VALID  = 1'b0;
        case (state_q)
            ST_INIT: begin
                DSP_RST = 1'b1;
                if (init_cnt_q == ICW'(INIT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + ICW'(1);
                end
            end
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                DSP_CE = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                capture = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    rsp_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            c_q        <= '0;
            opmode_q   <= '0;
            carryin_q  <= 1'b0;
            rsp_p_q    <= '0;
            rsp_co_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            if (accept) begin
                a_q       <= REQ_A;
                b_q       <= REQ_B;
                d_q       <= REQ_D;
                c_q       <= REQ_C;
                opmode_q  <= REQ_OPMODE;
                carryin_q <= REQ_CARRYIN;
            end
            if (capture) begin
                rsp_p_q  <= P;
                rsp_co_q <= CARRYOUT;
            end
        end
    end

`ifdef DSPSEQ_OPCOUNT_EN
    logic [15:0] op_count_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) op_count_q <= '0;
        else if (rsp_hs) op_count_q <= op_count_q + 16'd1;
    end
    assign OP_COUNT = op_count_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

    assign A            = a_q;
    assign B            = b_q;
    assign D            = d_q;
    assign C            = c_q;
    assign OPMODE       = opmode_q;
    assign CARRYIN      = carryin_q;
    assign RSP_P        = rsp_p_q;
    assign RSP_CARRYOUT = rsp_co_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Bench for dsp_op_sequencer: DSP slice stub, directed requests, queue-based response scoreboard.
module tb_dsp_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [17:0] REQ_A = '0, REQ_B = '0, REQ_D = '0;
    logic [47:0] REQ_C = '0;
    logic [7:0]  REQ_OPMODE = '0;
    logic        REQ_CARRYIN = 1'b0;
    logic [17:0] A, B, D;
    logic [47:0] C;
    logic [7:0]  OPMODE;
    logic        CARRYIN, DSP_CE, DSP_RST;
    logic [47:0] P;
    logic        CARRYOUT;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [47:0] RSP_P;
    logic        RSP_CARRYOUT;
    logic [2:0]  DBG_STATE;
`ifdef DSPSEQ_OPCOUNT_EN
    logic [15:0] OP_COUNT;
`endif

    dsp_op_sequencer dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_D(REQ_D), .REQ_C(REQ_C),
        .REQ_OPMODE(REQ_OPMODE), .REQ_CARRYIN(REQ_CARRYIN),
        .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .DSP_CE(DSP_CE), .DSP_RST(DSP_RST),
        .P(P), .CARRYOUT(CARRYOUT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_P(RSP_P), .RSP_CARRYOUT(RSP_CARRYOUT),
`ifdef DSPSEQ_OPCOUNT_EN
        .OP_COUNT(OP_COUNT),
`endif
        .DBG_STATE(DBG_STATE)
    );

    // Clock / cycle / CE bookkeeping
    always #5 CLK = ~CLK;

    int cyc = 0;
    int ce_total = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (DSP_CE) ce_total <= ce_total + 1;

    // Slice stub: P = A*B + C + CARRYIN through a 4-stage CE-gated pipe
    logic [48:0] pipe [4];
    logic [48:0] stub_sum;
    assign stub_sum = 49'(A) * 49'(B) + 49'(C) + 49'(CARRYIN);
    always @(posedge CLK) begin
        if (DSP_RST) begin
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end else if (DSP_CE) begin
            pipe[0] <= stub_sum;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign P        = pipe[3][47:0];
    assign CARRYOUT = pipe[3][48];

    int n_checks = 0;
    int n_fail   = 0;
    logic [48:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: a response transfers on the next edge when VALID&READY at negedge
    always @(negedge CLK) begin
        if (!RST && RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {15'd0, RSP_CARRYOUT, RSP_P}, 64'hDEAD);
            end else begin
                logic [48:0] e;
                e = exp_q.pop_front();
                check("rsp_p", {16'd0, RSP_P}, {16'd0, e[47:0]});
                check("rsp_carryout", {63'd0, RSP_CARRYOUT}, {63'd0, e[48]});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                            input logic cin, input logic expect_rsp, output int acc_cyc);
        logic [48:0] e;
        logic ok;
        ok = 1'b0;
        acc_cyc = -1;
        REQ_A = a; REQ_B = b; REQ_C = c; REQ_CARRYIN = cin;
        REQ_D = 18'h2A5; REQ_OPMODE = 8'h0D;
        REQ_VALID = 1'b1;
        e = 49'(a) * 49'(b) + 49'(c) + 49'(cin);
        if (expect_rsp) exp_q.push_back(e);
        for (int i = 0; i < 40; i++) begin
            if (REQ_READY) begin
                tick();
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        REQ_VALID = 1'b0;
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        logic ok;
        ok = 1'b0;
        rsp_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (RSP_VALID) begin
                rsp_cyc = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rsp_valid_timeout", 64'd0, 64'd1);
    endtask

    int acc1, acc2, rc, ce0;
    logic saw_valid;

    initial begin
        // 1: reset values and INIT release timing
        tick(); tick(); tick();
        check("rst_req_ready", {63'd0, REQ_READY}, 64'd0);
        check("rst_dsp_rst", {63'd0, DSP_RST}, 64'd1);
        check("rst_dsp_ce", {63'd0, DSP_CE}, 64'd0);
        check("rst_rsp_valid", {63'd0, RSP_VALID}, 64'd0);
        check("rst_pins", {A, B, C[27:0]}, 64'd0);
        check("rst_rsp_p", {15'd0, RSP_CARRYOUT, RSP_P}, 64'd0);
        RST = 1'b0;
        tick();
        check("init_hold_ready", {63'd0, REQ_READY}, 64'd0);
        check("init_hold_dsp_rst", {63'd0, DSP_RST}, 64'd1);
        tick();
        check("init_done_ready", {63'd0, REQ_READY}, 64'd1);
        check("init_done_dsp_rst", {63'd0, DSP_RST}, 64'd0);

        // 2: single op, latency and CE count
        RSP_READY = 1'b1;
        ce0 = ce_total;
        send_req(18'd5, 18'd6, 48'd100, 1'b1, 1'b1, acc1);
        check("pins_a", {46'd0, A}, 64'd5);
        check("pins_c", {16'd0, C}, 64'd100);
        wait_rsp(rc);
        check("latency", 64'(rc - acc1), 64'd5);
        tick();
        check("ce_clocks", 64'(ce_total - ce0), 64'd4);
        check("idle_after_hs", {63'd0, REQ_READY}, 64'd1);

        // 3: backpressure
        RSP_READY = 1'b0;
        send_req(18'd7, 18'd8, 48'd0, 1'b0, 1'b1, acc1);
        wait_rsp(rc);
        for (int i = 0; i < 10; i++) begin
            check("bp_ctrl", {61'd0, RSP_VALID, REQ_READY, DSP_CE}, 64'b100);
            check("bp_rsp_p", {16'd0, RSP_P}, 64'd56);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        check("bp_release_idle", {62'd0, REQ_READY, RSP_VALID}, 64'b10);

        // 4: back-to-back requests, ordering and re-accept spacing
        send_req(18'd20, 18'd10, 48'd350, 1'b0, 1'b1, acc1);
        send_req(18'd3, 18'd4, 48'd0, 1'b0, 1'b1, acc2);
        check("b2b_spacing", 64'(acc2 - acc1), 64'd7);
        wait_rsp(rc);
        tick();

        // 5: reset pulse mid-operation drops the op
        send_req(18'd9, 18'd9, 48'd0, 1'b0, 1'b0, acc1);
        tick();
        RST = 1'b1;
        #1;
        check("midrst_ce", {63'd0, DSP_CE}, 64'd0);
        check("midrst_dsp_rst", {63'd0, DSP_RST}, 64'd1);
        check("midrst_pins", {46'd0, A}, 64'd0);
        tick();
        RST = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (RSP_VALID) saw_valid = 1'b1;
            tick();
        end
        check("midrst_no_rsp", {63'd0, saw_valid}, 64'd0);
        send_req(18'd2, 18'd2, 48'd1, 1'b0, 1'b1, acc1);
        wait_rsp(rc);
        tick();

        // 6: 48-bit overflow into CARRYOUT
        send_req(18'd1, 18'd1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, acc1);
        wait_rsp(rc);
        tick();
`ifdef DSPSEQ_OPCOUNT_EN
        check("op_count", {48'd0, OP_COUNT}, 64'd2);
`endif
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
